// File: rtl/rob_alu_pkg.sv
// rob_alu_pkg: shared widths and op-type encoding for the decoder, the
// reservation station and the ALU. Codes 0..16 reach the ALU; the rest are
// remapped by the RS before issue and are listed here so every user of the
// package agrees on the numbering.
package rob_alu_pkg;

    localparam int TYPE_BIT      = 6;
    localparam int ROB_INDEX_BIT = 5;

    typedef enum logic [TYPE_BIT-1:0] {
        OP_ADD   = 6'd0,
        OP_SUB   = 6'd1,
        OP_SLL   = 6'd2,
        OP_SLT   = 6'd3,
        OP_SLTU  = 6'd4,
        OP_XOR   = 6'd5,
        OP_SRL   = 6'd6,
        OP_SRA   = 6'd7,
        OP_OR    = 6'd8,
        OP_AND   = 6'd9,
        OP_BEQ   = 6'd10,
        OP_BNE   = 6'd11,
        OP_BLT   = 6'd12,
        OP_BGE   = 6'd13,
        OP_BLTU  = 6'd14,
        OP_BGEU  = 6'd15,
        OP_JALR  = 6'd16,
        // Forms below are rewritten by the RS and never issued to the ALU.
        OP_ADDI  = 6'd17,
        OP_SLTI  = 6'd18,
        OP_SLTIU = 6'd19,
        OP_XORI  = 6'd20,
        OP_ORI   = 6'd21,
        OP_ANDI  = 6'd22,
        OP_SLLI  = 6'd23,
        OP_SRLI  = 6'd24,
        OP_SRAI  = 6'd25,
        OP_LUI   = 6'd26,
        OP_AUIPC = 6'd27,
        OP_JAL   = 6'd28,
        OP_LB    = 6'd29,
        OP_LH    = 6'd30,
        OP_LW    = 6'd31,
        OP_LBU   = 6'd32,
        OP_LHU   = 6'd33,
        OP_SB    = 6'd34,
        OP_SH    = 6'd35,
        OP_SW    = 6'd36
    } op_e;

    // True for op codes whose result is a one-bit branch condition.
    function automatic logic is_branch(input logic [TYPE_BIT-1:0] code);
        return (code >= OP_BEQ) && (code <= OP_BGEU);
    endfunction

endpackage

// File: rtl/rob_alu_comb.sv
// rob_alu_comb: purely combinational RV32I function unit.
// Maps (inst_type, r1, r2) to a 32-bit value; unknown codes give zero.
module rob_alu_comb
    import rob_alu_pkg::*;
(
    input  logic [TYPE_BIT-1:0] inst_type,
    input  logic [31:0]         r1,
    input  logic [31:0]         r2,
    output logic [31:0]         value
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;
    logic       equal;
    logic       cond;

    assign shamt       = r2[4:0];
    assign lt_signed   = $signed(r1) < $signed(r2);
    assign lt_unsigned = r1 < r2;
    assign equal       = r1 == r2;

    // Branch condition select, kept apart so branch results share one zero-extend.
    always_comb begin
        cond = 1'b0;
        case (inst_type)
            OP_BEQ:  cond = equal;
            OP_BNE:  cond = !equal;
            OP_BLT:  cond = lt_signed;
            OP_BGE:  cond = !lt_signed;
            OP_BLTU: cond = lt_unsigned;
            OP_BGEU: cond = !lt_unsigned;
            default: cond = 1'b0;
        endcase
    end

    // Main result mux; all arithmetic wraps at 32 bits.
    always_comb begin
        value = '0;
        if (is_branch(inst_type)) begin
            value = {31'b0, cond};
        end else begin
            case (inst_type)
                OP_ADD:  value = r1 + r2;
                OP_SUB:  value = r1 - r2;
                OP_SLL:  value = r1 << shamt;
                OP_SLT:  value = {31'b0, lt_signed};
                OP_SLTU: value = {31'b0, lt_unsigned};
                OP_XOR:  value = r1 ^ r2;
                OP_SRL:  value = r1 >> shamt;
                OP_SRA:  value = $unsigned($signed(r1) >>> shamt);
                OP_OR:   value = r1 | r2;
                OP_AND:  value = r1 & r2;
                OP_JALR: value = (r1 + r2) & 32'hFFFF_FFFE;
                default: value = '0;
            endcase
        end
    end

endmodule

// File: rtl/rob_alu.sv
// rob_alu: single-issue ALU inside the reservation station. Registers the
// function-unit result with its ROB tag and pulses ready one cycle later.
// Build option: define ALU_ZERO_IDLE_EN to clear result/tag on idle cycles;
// otherwise they hold their last values.
module rob_alu
    import rob_alu_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [TYPE_BIT-1:0]      inst_type,
    input  logic                     req,
    input  logic [31:0]              r1,
    input  logic [31:0]              r2,
    input  logic [ROB_INDEX_BIT-1:0] rob_id_in,
    output logic                     ready,
    output logic [ROB_INDEX_BIT-1:0] rob_id_out,
    output logic [31:0]              result
);

    logic [31:0]              alu_next;
    logic                     ready_reg;
    logic [ROB_INDEX_BIT-1:0] rob_id_reg;
    logic [31:0]              result_reg;

    rob_alu_comb u_comb (
        .inst_type (inst_type),
        .r1        (r1),
        .r2        (r2),
        .value     (alu_next)
    );

    // Write-back register: stalls freeze everything, a req is simply dropped.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ready_reg  <= 1'b0;
            rob_id_reg <= '0;
            result_reg <= '0;
        end else if (rdy_in) begin
            ready_reg <= req;
            if (req) begin
                rob_id_reg <= rob_id_in;
                result_reg <= alu_next;
            end else begin
`ifdef ALU_ZERO_IDLE_EN
                rob_id_reg <= '0;
                result_reg <= '0;
`else
                rob_id_reg <= rob_id_reg;
                result_reg <= result_reg;
`endif
            end
        end
    end

    assign ready      = ready_reg;
    assign rob_id_out = rob_id_reg;
    assign result     = result_reg;

endmodule

// File: tb/tb_rob_alu.sv
// tb_rob_alu: directed plus random checks of rob_alu against an arithmetic
// reference model. Honors ALU_ZERO_IDLE_EN for the idle-cycle expectation.
`timescale 1ns/1ps
module tb_rob_alu;
    import rob_alu_pkg::*;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic [TYPE_BIT-1:0]      inst_type;
    logic                     req;
    logic [31:0]              r1;
    logic [31:0]              r2;
    logic [ROB_INDEX_BIT-1:0] rob_id_in;
    logic                     ready;
    logic [ROB_INDEX_BIT-1:0] rob_id_out;
    logic [31:0]              result;

    int n_assert = 0;
    int n_fail   = 0;

    logic        e_ready;
    logic [4:0]  e_tag;
    logic [31:0] e_res;

    rob_alu dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .inst_type  (inst_type),
        .req        (req),
        .r1         (r1),
        .r2         (r2),
        .rob_id_in  (rob_id_in),
        .ready      (ready),
        .rob_id_out (rob_id_out),
        .result     (result)
    );

    always #5 clk_in = ~clk_in;

    // Reference: RV32I semantics with wide integer arithmetic.
    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p2 = 1;
        longint q;
        for (int k = 0; k < int'(b[4:0]); k++) p2 = p2 * 2;
        case (op)
            0:  return 32'(ua + ub);
            1:  return 32'(ua - ub);
            2:  return 32'(ua * p2);
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (ua < ub) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return 32'(ua / p2);
            7: begin
                if (sa >= 0) q = sa / p2;
                else         q = -((-sa + p2 - 1) / p2);
                return 32'(q);
            end
            8:  return a | b;
            9:  return a & b;
            10: return (ua == ub) ? 32'd1 : 32'd0;
            11: return (ua != ub) ? 32'd1 : 32'd0;
            12: return (sa < sb)  ? 32'd1 : 32'd0;
            13: return (sa >= sb) ? 32'd1 : 32'd0;
            14: return (ua < ub)  ? 32'd1 : 32'd0;
            15: return (ua >= ub) ? 32'd1 : 32'd0;
            16: return 32'(ua + ub) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ".ready"},  {31'b0, ready},     {31'b0, e_ready});
        chk({tag, ".tag"},    {27'b0, rob_id_out}, {27'b0, e_tag});
        chk({tag, ".result"}, result,              e_res);
    endtask

    // One clock: drive at edge+1, update the model, check at next edge+1.
    task automatic cycle(string tag, logic rdy, logic rq, int op,
                         logic [31:0] a, logic [31:0] b, logic [4:0] id);
        rdy_in    = rdy;
        req       = rq;
        inst_type = 6'(op);
        r1        = a;
        r2        = b;
        rob_id_in = id;
        if (rdy) begin
            e_ready = rq;
            if (rq) begin
                e_tag = id;
                e_res = ref_alu(op, a, b);
            end else begin
`ifdef ALU_ZERO_IDLE_EN
                e_tag = '0;
                e_res = '0;
`endif
            end
        end
        @(posedge clk_in);
        #1;
        $display("txn %-10s rdy=%0b req=%0b op=%0d r1=%08h r2=%08h id=%0d -> ready=%0b tag=%0d result=%08h",
                 tag, rdy, rq, op, a, b, id, ready, rob_id_out, result);
        check_outputs(tag);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; req = 1'b0; inst_type = '0;
        r1 = '0; r2 = '0; rob_id_in = '0;
        e_ready = 1'b0; e_tag = '0; e_res = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check_outputs("reset");
        rst_in = 1'b1;

        // Stalled reqs right after reset must be lost.
        repeat (3) cycle("stall", 1'b0, 1'b1, OP_ADD, 32'd9, 32'd9, 5'd9);

        cycle("add_wrap", 1'b1, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd7);
        chk("add_wrap.const", result, 32'h0);
        cycle("sub", 1'b1, 1'b1, OP_SUB, 32'd5, 32'd7, 5'd8);
        chk("sub.const", result, 32'hFFFF_FFFE);
        cycle("idle", 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);

        cycle("sll", 1'b1, 1'b1, OP_SLL, 32'h8000_0000, 32'h21, 5'd10);
        chk("sll.const", result, 32'h0);
        cycle("srl", 1'b1, 1'b1, OP_SRL, 32'h8000_0000, 32'h21, 5'd11);
        chk("srl.const", result, 32'h4000_0000);
        cycle("sra", 1'b1, 1'b1, OP_SRA, 32'h8000_0000, 32'h21, 5'd12);
        chk("sra.const", result, 32'hC000_0000);

        cycle("slt",  1'b1, 1'b1, OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd13);
        chk("slt.const", result, 32'd1);
        cycle("sltu", 1'b1, 1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd14);
        chk("sltu.const", result, 32'd0);
        cycle("blt",  1'b1, 1'b1, OP_BLT,  32'hFFFF_FFFF, 32'd1, 5'd15);
        chk("blt.const", result, 32'd1);
        cycle("bgeu", 1'b1, 1'b1, OP_BGEU, 32'hFFFF_FFFF, 32'd1, 5'd16);
        chk("bgeu.const", result, 32'd1);
        cycle("beq",  1'b1, 1'b1, OP_BEQ,  32'd3, 32'd3, 5'd17);
        chk("beq.const", result, 32'd1);
        cycle("bne",  1'b1, 1'b1, OP_BNE,  32'd3, 32'd3, 5'd18);
        chk("bne.const", result, 32'd0);

        // Back-to-back: ready stays high and tags follow in order.
        cycle("b2b1", 1'b1, 1'b1, OP_JALR, 32'h1000, 32'h7, 5'd1);
        chk("b2b1.const", result, 32'h1006);
        cycle("b2b2", 1'b1, 1'b1, OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2);
        cycle("b2b3", 1'b1, 1'b1, 63,      32'h1234_5678, 32'h1, 5'd3);
        chk("undef.const", result, 32'h0);
        chk("undef.ready", {31'b0, ready}, 32'd1);

        // Idle behaviour with and without the zero-idle build option.
        cycle("feat_add",  1'b1, 1'b1, OP_ADD, 32'd2, 32'd3, 5'd4);
        chk("feat_add.const", result, 32'd5);
        cycle("feat_idle", 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);
`ifdef ALU_ZERO_IDLE_EN
        chk("feat_idle.res_const", result, 32'd0);
        chk("feat_idle.tag_const", {27'b0, rob_id_out}, 32'd0);
`else
        chk("feat_idle.res_const", result, 32'd5);
        chk("feat_idle.tag_const", {27'b0, rob_id_out}, 32'd4);
`endif

        // Asynchronous reset landing mid-cycle with a req pending.
        cycle("pre_rst", 1'b1, 1'b1, OP_OR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd21);
        req = 1'b1; inst_type = OP_ADD; r1 = 32'd100; r2 = 32'd1; rob_id_in = 5'd22;
        #3;
        rst_in = 1'b0;
        #1;
        e_ready = 1'b0; e_tag = '0; e_res = '0;
        check_outputs("async_rst");
        @(posedge clk_in);
        #1;
        check_outputs("rst_hold");
        rst_in = 1'b1;

        // Random traffic with stalls, idles and undefined codes mixed in.
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 63))
                                              : int'($urandom_range(0, 16));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            cycle("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
                  op, a, b, 5'($urandom));
        end
        cycle("drain", 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_alu.md
Name: rob_alu

Overview:
- Single-issue integer ALU that sits inside the reservation station.
- Each cycle the RS presents at most one ready operation (operands, op type, ROB tag).
- The ALU computes the RV32I result and registers it with the tag.
- Result is broadcast to the ROB one cycle later as a write-back pulse.

Parameters:
- TYPE_BIT, 6, width of the op-type code.
- ROB_INDEX_BIT, 5, width of the ROB tag.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; low = stall, all state held.
- inst_type  in  TYPE_BIT  operation code (package encoding).
- req  in  1  operation valid this cycle.
- r1  in  32  operand 1.
- r2  in  32  operand 2 (register value or immediate).
- rob_id_in  in  ROB_INDEX_BIT  destination ROB tag.
- ready  out  1  registered write-back valid.
- rob_id_out  out  ROB_INDEX_BIT  registered tag of the result.
- result  out  32  registered result.

Behaviour:
- Reset: rst_in low asynchronously forces ready=0, rob_id_out=0, result=0. These are held while rst_in is low, including mid-operation; a pending req is dropped.
- Rising edge with rdy_in=0: all outputs hold; req is ignored and lost. The caller must not retire the slot while stalled.
- Rising edge with rdy_in=1:
  - ready <= req.
  - If req=1: rob_id_out <= rob_id_in, result <= f(inst_type, r1, r2).
  - If req=0: rob_id_out and result hold (baseline).
- Latency is exactly 1 cycle. Throughput is 1 op per cycle; back-to-back reqs give a continuous ready high. There is no backpressure; the consumer must accept every pulse.
- Arithmetic and logic (all 32-bit, wrap-around, no overflow flag):
  - ADD: r1+r2. SUB: r1-r2.
  - AND, OR, XOR: bitwise.
  - SLL: r1 << r2[4:0]. SRL: logical right shift by r2[4:0]. SRA: arithmetic right shift by r2[4:0].
  - SLT: signed r1<r2 → 1, else 0. SLTU: the same comparison, unsigned.
- Branches (result is the condition: 1 = taken, 0 = not taken; upper 31 bits zero):
  - BEQ: r1==r2. BNE: r1!=r2.
  - BLT: signed <. BGE: signed >=.
  - BLTU: unsigned <. BGEU: unsigned >=.
- JALR: (r1+r2) & 0xFFFF_FFFE (jump target, LSB cleared).
- Immediate, LUI, AUIPC and JAL forms are pre-mapped by the RS onto ADD/SLT/etc.; the ALU never sees their codes.
- Undefined inst_type with req=1: result=0, ready still pulses with the tag.
- Combinational datapath from inputs to the result register only; outputs have no combinational path from inputs.

Optional Feature:
- Macro: ALU_ZERO_IDLE_EN.
- Defined: on an rdy_in=1 edge with req=0, result and rob_id_out are cleared to 0 (clean idle bus, eases waveform and trace diffing).
- Undefined: they hold their last values.
- ready behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - TYPE_BIT=6 and ROB_INDEX_BIT=5.
  - Op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, BEQ=10, BNE=11, BLT=12, BGE=13, BLTU=14, BGEU=15, JALR=16.
  - The remaining RV32I codes (ADDI..SRAI, LUI, AUIPC, JAL, loads/stores) from 17 upward, shared with the decoder and RS.
- Natural sub-module: rob_alu_comb, a purely combinational function unit (type, r1, r2 → 32-bit value); rob_alu wraps it with the output registers.

Test Plan:
- Reset/stall:
  - Drive a req, then rst_in=0 mid-cycle → ready=0, result=0, rob_id_out=0 immediately.
  - Release reset, req with rdy_in=0 for 3 cycles → outputs unchanged, ready stays 0.
- Arithmetic:
  - ADD 0xFFFFFFFF+1 tag 7 → next cycle ready=1, result=0, rob_id_out=7.
  - SUB 5-7 → 0xFFFFFFFE.
  - The following cycle, req=0 → ready=0.
- Shifts: r1=0x80000000, r2=0x21 (shamt 1):
  - SLL → 0.
  - SRL → 0x40000000.
  - SRA → 0xC0000000.
- Compares: r1=0xFFFFFFFF, r2=1:
  - SLT → 1; SLTU → 0.
  - BLT → 1; BGEU → 1.
  - BEQ with r1=r2=3 → 1; BNE with r1=r2=3 → 0.
- JALR, back-to-back: tags 1, 2, 3 on consecutive cycles.
  - JALR 0x1000+0x7 → 0x1006.
  - Also check: ready high 3 consecutive cycles with matching tags in order; undefined type 63 → result 0, ready=1.
- Feature: with ALU_ZERO_IDLE_EN, ADD 2+3 tag 4, then idle → result 5/tag 4, then 0/0. Without the macro → 5/4 held.
